// File: rtl/reaction_control_pkg.sv
// Reaction-timer controller shared types: FSM states and display screen codes.
// The display block decodes oScreen with the same SCR_* constants.
package reaction_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_GO,
        ST_MEASURE,
        ST_SCORE,
        ST_RESULT
    } state_t;

    localparam logic [1:0] SCR_IDLE   = 2'd0;
    localparam logic [1:0] SCR_WAIT   = 2'd1;
    localparam logic [1:0] SCR_GO     = 2'd2;
    localparam logic [1:0] SCR_RESULT = 2'd3;

    // ARM shows the wait screen, SCORE keeps the go screen for its single cycle
    function automatic logic [1:0] screen_of(input state_t s);
        logic [1:0] scr;
        scr = SCR_IDLE;
        case (s)
            ST_ARM, ST_WAIT:               scr = SCR_WAIT;
            ST_GO, ST_MEASURE, ST_SCORE:   scr = SCR_GO;
            ST_RESULT:                     scr = SCR_RESULT;
            default:                       scr = SCR_IDLE;
        endcase
        return scr;
    endfunction

endpackage

// File: rtl/reaction_control_button_sync_edge.sv
// Push-button synchronizer plus rising-edge detector producing a one-clk press.
// A button already held when reset releases must be seen low before it can press.
module button_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_resetn,
    input  logic i_btn,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];
    assign o_press = w_level & ~r_prev & r_armed;

    // r_fill marks when the chain holds real samples rather than reset zeros
    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_level;
            if (r_fill[SYNC_STAGES-1] && !w_level) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reaction_control.sv
// Reaction-timer game controller: sequences the datapath counters and the
// display, detects false starts and no-response timeouts.
module reaction_control
    import reaction_control_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 4095,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iGo,
    input  logic       iReact,
    input  logic       iTick,
    input  logic       iCountComplete,
    output logic       oStart_down_count,
    output logic       oStart_up_count,
    output logic       oLoad_score,
    output logic [1:0] oScreen,
    output logic       oFalseStart,
    output logic       oTimeout
);

    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT_TICKS);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_false;
    logic          r_timeout;
    logic          w_go;
    logic          w_react;

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_go_sync (
        .clk      (clk),
        .i_resetn (iResetn),
        .i_btn    (iGo),
        .o_press  (w_go)
    );

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_react_sync (
        .clk      (clk),
        .i_resetn (iResetn),
        .i_btn    (iReact),
        .o_press  (w_react)
    );

    always_ff @(posedge clk) begin
        if (!iResetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_false   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state   <= ST_ARM;
                        r_false   <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (iTick) r_state <= ST_WAIT;
                end
                // a react press beats a simultaneous countdown completion
                ST_WAIT: begin
                    if (w_react) begin
                        r_state <= ST_RESULT;
                        r_false <= 1'b1;
                    end else if (iCountComplete) begin
                        r_state <= ST_GO;
                    end
                end
                ST_GO: begin
                    if (iTick) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_react) begin
                        r_state <= ST_SCORE;
                    end else if (iTick) begin
                        if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state   <= ST_RESULT;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_SCORE: begin
                    r_state <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (w_go) begin
                        r_state   <= ST_ARM;
                        r_false   <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oScreen           = screen_of(r_state);
    assign oStart_down_count = (r_state == ST_ARM);
    assign oStart_up_count   = (r_state == ST_GO);
    assign oLoad_score       = (r_state == ST_SCORE);
    assign oFalseStart       = r_false;
    assign oTimeout          = r_timeout;

endmodule

// File: doc/reaction_control.md
REACTION_CONTROL -- requirements
Module: reaction_control

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 4095: number of iTick strobes in MEASURE before a no-response timeout.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for button inputs, legal range 2..3.
REQ-003 clk  input  1  system clock; sole clock, all state updates on its rising edge.
REQ-004 iResetn  input  1  synchronous reset, active-low.
REQ-005 iGo  input  1  start/acknowledge push-button, asynchronous level.
REQ-006 iReact  input  1  player reaction push-button, asynchronous level.
REQ-007 iTick  input  1  one-clk-wide strobe from the datapath slow-clock divider (datapath counter advance).
REQ-008 iCountComplete  input  1  datapath random-delay countdown reached zero.
REQ-009 oStart_down_count  output  1  load/hold of the datapath random-delay counter.
REQ-010 oStart_up_count  output  1  clear/hold of the datapath reaction up-counter.
REQ-011 oLoad_score  output  1  single-clk pulse; datapath latches current and best score.
REQ-012 oScreen  output  2  display select: 0 idle, 1 wait, 2 go, 3 result.
REQ-013 oFalseStart  output  1  high while result screen shows a false start.
REQ-014 oTimeout  output  1  high while result screen shows a no-response timeout.

Function
REQ-015 iGo and iReact each pass through a SYNC_STAGES flop synchronizer then a rising-edge detector; "press" means one-clk edge pulse; all FSM decisions use press pulses only.
REQ-016 FSM states: IDLE, ARM, WAIT, GO, MEASURE, SCORE, RESULT.
REQ-017 IDLE: oScreen=0; iGo press -> ARM.
REQ-018 ARM: oStart_down_count=1; stay until first iTick, then WAIT on the cycle after that iTick (guarantees datapath reload on its slow clock).
REQ-019 WAIT: oScreen=1; iReact press -> RESULT with false-start flag set; else iCountComplete=1 -> GO; react press and iCountComplete in same cycle -> false start wins.
REQ-020 GO: oStart_up_count=1, oScreen=2; stay until first iTick, then MEASURE.
REQ-021 MEASURE: oScreen=2; timeout counter increments on each iTick; iReact press -> SCORE; counter reaching TIMEOUT_TICKS with no press -> RESULT with timeout flag set; press and terminal tick same cycle -> SCORE.
REQ-022 SCORE: oLoad_score=1 for exactly one clk, then RESULT; oLoad_score never asserted outside SCORE.
REQ-023 RESULT: oScreen=3; oFalseStart/oTimeout reflect flags; iGo press -> ARM (flags cleared on ARM entry); iReact ignored.
REQ-024 Timeout counter width = clog2(TIMEOUT_TICKS+1); cleared on entry to MEASURE; saturates, never wraps.
REQ-025 iGo presses in ARM, WAIT, GO, MEASURE, SCORE ignored; presses in IDLE/RESULT take effect next cycle (one-clk FSM latency).
REQ-026 All outputs registered or pure decodes of state/flag registers; no input-to-output combinational path.
REQ-027 Flags oFalseStart and oTimeout mutually exclusive.

Reset
REQ-028 iResetn=0 at a clk edge: state IDLE, synchronizers and edge history 0, timeout counter 0, flags 0; all outputs 0; oScreen=0.
REQ-029 Reset mid-game (any state) aborts the round in one cycle with no oLoad_score pulse; a button held through reset release produces no press.

Structure
REQ-030 Shared package holds state enumeration and oScreen codes (SCR_IDLE/SCR_WAIT/SCR_GO/SCR_RESULT), reused by the display block.
REQ-031 One sub-module: button_sync_edge (synchronizer plus rising-edge detector), instantiated twice.

Verification
REQ-032 Normal round: iGo press, iTick every 50 clk, iCountComplete after 200 ticks, iReact at tick 300 of MEASURE -> screens 0,1,2,3; exactly one oLoad_score; oFalseStart=oTimeout=0.
REQ-033 False start: iReact press during WAIT -> RESULT next cycle, oFalseStart=1, no oLoad_score, oStart_up_count never asserted.
REQ-034 Timeout with TIMEOUT_TICKS=10: no iReact -> RESULT on the cycle after the 10th MEASURE tick, oTimeout=1, no oLoad_score.
REQ-035 Coincidence: iReact press with iCountComplete in WAIT -> false start; iReact press with terminal tick in MEASURE -> SCORE.
REQ-036 Reset in MEASURE: iResetn low one clk -> all outputs 0, IDLE; iGo held high across release -> stays IDLE until released and repressed.
REQ-037 Restart: iGo press in RESULT after false start -> ARM with flags 0, oStart_down_count high until next iTick.
